// File: rtl/fork_join_ctrl.sv
// Fork/join controller: launches up to NUM_CH timed countdown channels on one
// start and emits a single join_done pulse under JOIN / JOIN_ANY / JOIN_NONE.
module fork_join_ctrl #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*CNT_W-1:0] dur,
  output logic                    ready,
  output logic [NUM_CH-1:0]       ch_busy,
  output logic [NUM_CH-1:0]       ch_start,
  output logic [NUM_CH-1:0]       ch_done,
  output logic                    join_done,
  output logic [CNT_W:0]          join_lat
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [1:0] M_JOIN_ANY  = 2'b01;
  localparam logic [1:0] M_JOIN_NONE = 2'b10;

  localparam logic [CNT_W:0]   LAT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [NUM_CH-1:0] ch_start_q;
  logic [1:0]        mode_q;
  logic              join_pend_q;
  logic              join_done_q;
  logic [CNT_W:0]    lat_cnt_q;
  logic [CNT_W:0]    join_lat_q;

  logic              accept;
  logic              join_immediate;
  logic              join_cond;
  logic [NUM_CH-1:0] tail_busy;
  logic [CNT_W:0]    lat_next;

  // A channel is busy while its counter is non-zero; count==1 is its last cycle,
  // and tail_busy marks channels that are still busy after the current cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ch_busy   = '0;
    ch_done   = '0;
    tail_busy = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_busy[i]   = (cnt_q[i] != '0);
      ch_done[i]   = (cnt_q[i] == CNT_ONE);
      tail_busy[i] = (cnt_q[i] > CNT_ONE);
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign accept    = start && ready;
  assign ch_start  = ch_start_q;
  assign join_done = join_done_q;
  assign join_lat  = join_lat_q;

  // With nothing enabled, JOIN and JOIN_ANY are satisfied vacuously at acceptance.
  assign join_immediate = (mode == M_JOIN_NONE) || (ch_en == '0);

  assign lat_next = (lat_cnt_q == LAT_MAX) ? LAT_MAX : lat_cnt_q + 1'b1;

  // Mode 11 is reserved and falls through to JOIN semantics.
  always_comb begin
    join_cond = 1'b0;
    if (join_pend_q) begin
      if (mode_q == M_JOIN_ANY) join_cond = |ch_done;
      else                      join_cond = ~|tail_busy;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (join_done_q) state_d = (|tail_busy) ? S_DRAIN : S_IDLE;
      S_DRAIN: if (!(|tail_busy)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Channel countdowns: dur=0 is promoted to a single busy cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      ch_start_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept) begin
          if (!ch_en[i])                              cnt_q[i] <= '0;
          else if (dur[i*CNT_W +: CNT_W] == '0)       cnt_q[i] <= CNT_ONE;
          else                                        cnt_q[i] <= dur[i*CNT_W +: CNT_W];
        end else if (cnt_q[i] != '0) begin
          cnt_q[i] <= cnt_q[i] - CNT_ONE;
        end
      end
      ch_start_q <= accept ? ch_en : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      join_pend_q <= 1'b0;
      join_done_q <= 1'b0;
      lat_cnt_q   <= '0;
      join_lat_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mode_q      <= mode;
        join_pend_q <= !join_immediate;
        join_done_q <= join_immediate;
        lat_cnt_q   <= '0;
        if (join_immediate) join_lat_q <= '0;
      end else begin
        join_done_q <= join_cond;
        if (join_cond) begin
          join_pend_q <= 1'b0;
          join_lat_q  <= lat_next;
        end
        // Latency counter reads k-1 in cycle A+k, so the join cycle sees lat_next.
        if (join_pend_q) lat_cnt_q <= lat_next;
      end
    end
  end

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Self-checking bench for fork_join_ctrl: directed scenarios plus random forks,
// compared cycle by cycle against a timeline model derived from the join rules.
module tb_fork_join_ctrl;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;
  localparam int VW     = 2 + 3 * NUM_CH;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    start;
  logic [1:0]              mode;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH*CNT_W-1:0] dur;
  logic                    ready;
  logic [NUM_CH-1:0]       ch_busy;
  logic [NUM_CH-1:0]       ch_start;
  logic [NUM_CH-1:0]       ch_done;
  logic                    join_done;
  logic [CNT_W:0]          join_lat;

  int n_cmp = 0;
  int n_err = 0;
  int fork_id = 0;
  int prev_lat = 0;

  fork_join_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .ch_en(ch_en), .dur(dur),
    .ready(ready), .ch_busy(ch_busy), .ch_start(ch_start), .ch_done(ch_done),
    .join_done(join_done), .join_lat(join_lat)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] observed();
    return {ready, ch_busy, ch_start, ch_done, join_done};
  endfunction

  function automatic logic [VW-1:0] idle_vec();
    logic [VW-1:0] v;
    v = '0;
    v[VW-1] = 1'b1;
    return v;
  endfunction

  // Runs one fork. Inputs are driven at the call point (between edges); the next
  // rising edge is cycle A. abort_at>0 pulls reset at offset abort_at instead.
  task automatic do_fork(input logic [1:0] m, input logic [NUM_CH-1:0] en,
                         input logic [NUM_CH*CNT_W-1:0] d, input bit noise,
                         input int abort_at);
    int dd [NUM_CH];
    int max_d, min_d, jk, rk, new_lat, waited;
    logic [NUM_CH-1:0] e_busy, e_start, e_done;
    logic e_rdy, e_jd;
    string tag;

    fork_id++;
    max_d = 0;
    min_d = 1 << 30;
    for (int i = 0; i < NUM_CH; i++) begin
      dd[i] = int'(d[i*CNT_W +: CNT_W]);
      if (dd[i] == 0) dd[i] = 1;
      if (en[i]) begin
        if (dd[i] > max_d) max_d = dd[i];
        if (dd[i] < min_d) min_d = dd[i];
      end
    end
    if (en == '0 || m == 2'b10) jk = 1;
    else if (m == 2'b01)        jk = min_d + 1;
    else                        jk = max_d + 1;
    rk = ((jk > max_d) ? jk : max_d) + 1;
    new_lat = jk - 1;

    waited = 0;
    while (!ready && waited < 600) begin
      @(negedge clk);
      waited++;
    end
    if (!ready) begin
      check($sformatf("f%0d ready_timeout", fork_id), {63'd0, ready}, 64'd1);
      return;
    end

    start = 1'b1; mode = m; ch_en = en; dur = d;
    @(posedge clk);
    #1;
    start = 1'b0;

    for (int k = 1; k <= rk; k++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_CH; i++) begin
        e_busy[i]  = en[i] && (k <= dd[i]);
        e_start[i] = en[i] && (k == 1);
        e_done[i]  = en[i] && (k == dd[i]);
      end
      e_jd  = (k == jk);
      e_rdy = (k >= rk);
      tag = $sformatf("f%0d k%0d outputs", fork_id, k);
      check(tag, 64'(observed()), 64'({e_rdy, e_busy, e_start, e_done, e_jd}));
      if (k > jk)      check($sformatf("f%0d k%0d join_lat", fork_id, k), 64'(join_lat), 64'(new_lat));
      else if (k < jk) check($sformatf("f%0d k%0d join_lat_held", fork_id, k), 64'(join_lat), 64'(prev_lat));

      if (abort_at > 0 && k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check($sformatf("f%0d async_reset", fork_id), 64'(observed()), 64'(idle_vec()));
        check($sformatf("f%0d async_reset_lat", fork_id), 64'(join_lat), 64'd0);
        for (int r = 0; r < 3; r++) begin
          @(negedge clk);
          check($sformatf("f%0d in_reset%0d", fork_id, r), 64'(observed()), 64'(idle_vec()));
        end
        rst_n = 1'b1;
        prev_lat = 0;
        return;
      end

      if (noise && k < rk) begin
        start = 1'($urandom_range(0, 1));
        mode  = 2'($urandom);
        ch_en = NUM_CH'($urandom);
        dur   = (NUM_CH*CNT_W)'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    prev_lat = new_lat;
  endtask

  initial begin
    logic [1:0]              rm;
    logic [NUM_CH-1:0]       ren;
    logic [NUM_CH*CNT_W-1:0] rd;

    rst_n = 1'b0; start = 1'b0; mode = '0; ch_en = '0; dur = '0;
    #1;
    check("reset_outputs", 64'(observed()), 64'(idle_vec()));
    check("reset_join_lat", 64'(join_lat), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 64'(observed()), 64'(idle_vec()));

    do_fork(2'b00, 2'b11, {8'd30, 8'd20}, 1'b0, 0);  // JOIN
    do_fork(2'b01, 2'b11, {8'd30, 8'd20}, 1'b1, 0);  // JOIN_ANY, ignored starts
    do_fork(2'b10, 2'b11, {8'd30, 8'd20}, 1'b0, 0);  // JOIN_NONE
    do_fork(2'b00, 2'b11, {8'd0, 8'd0},   1'b0, 0);  // dur=0 -> 1
    do_fork(2'b00, 2'b00, {8'd9, 8'd9},   1'b0, 0);  // nothing enabled
    do_fork(2'b01, 2'b00, {8'd9, 8'd9},   1'b0, 0);
    do_fork(2'b10, 2'b00, {8'd9, 8'd9},   1'b0, 0);
    do_fork(2'b01, 2'b11, {8'd5, 8'd5},   1'b0, 0);  // simultaneous completions
    do_fork(2'b00, 2'b11, {8'd30, 8'd20}, 1'b0, 10); // reset mid-run
    do_fork(2'b00, 2'b11, {8'd3, 8'd3},   1'b0, 0);
    do_fork(2'b11, 2'b11, {8'd4, 8'd2},   1'b1, 0);  // reserved mode = JOIN
    do_fork(2'b00, 2'b01, {8'd7, 8'd255}, 1'b0, 0);  // max duration
    do_fork(2'b01, 2'b10, {8'd1, 8'd6},   1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      rm  = 2'($urandom);
      ren = NUM_CH'($urandom);
      rd  = (NUM_CH*CNT_W)'($urandom);
      for (int i = 0; i < NUM_CH; i++)
        if ($urandom_range(0, 7) != 0) rd[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 12));
      do_fork(rm, ren, rd, 1'($urandom_range(0, 1)), 0);
    end

    repeat (2) @(negedge clk);
    check("final_idle", 64'(observed()), 64'(idle_vec()));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
